// File: rtl/uart_pkg.sv
// Shared 8N1 frame definitions for the board UART receiver and transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int   DATA_BITS   = 8;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    function automatic int clks_per_bit(input int f, input int baud);
        return f / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side bundle: serial line in, assembled byte plus status strobes out.
interface uart_rx_if;
    import uart_pkg::*;

    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 frame_err;
    logic                 busy;

    modport master (input rx, output data, output valid, output frame_err, output busy);
    modport slave  (output rx, input data, input valid, input frame_err, input busy);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; INIT is the reset level.
module sync_2ff #(
    parameter logic INIT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_reg <= INIT;
            sync_reg <= INIT;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised line, mid-bit sampling, one-cycle valid/frame_err strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD = 115200,
    parameter int F    = 50000000
) (
    input logic        clk,
    input logic        rst,
    uart_rx_if.master  bus
);
    localparam int CLKS_PER_BIT = clks_per_bit(F, BAUD);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam logic [15:0] CNT_BIT_END  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] CNT_HALF_END = 16'(HALF_BIT - 1);
    localparam logic [2:0]  IDX_LAST     = 3'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_t          state_reg;
    logic [15:0]          cnt_reg;
    logic [2:0]           idx_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] data_reg;
    logic                 valid_reg;
    logic                 frame_err_reg;
    logic                 sample_data;

    sync_2ff #(.INIT(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.rx),
        .q   (rx_s)
    );

    assign sample_data = (state_reg == DATA) && (cnt_reg == CNT_BIT_END);

    // Each shift bit owns its own capture so the byte assembles LSB first by index.
    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                shift_reg[gi] <= 1'b0;
            end else if (sample_data && (idx_reg == 3'(gi))) begin
                shift_reg[gi] <= rx_s;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (rx_s == START_LEVEL) begin
                        state_reg <= START;
                    end
                end
                START: begin
                    if (cnt_reg == CNT_HALF_END) begin
                        cnt_reg <= '0;
                        idx_reg <= '0;
                        // A line back high at mid-start was only a glitch.
                        state_reg <= (rx_s == START_LEVEL) ? DATA : IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt_reg == CNT_BIT_END) begin
                        cnt_reg <= '0;
                        if (idx_reg == IDX_LAST) begin
                            state_reg <= STOP;
                        end else begin
                            idx_reg <= idx_reg + 3'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                STOP: begin
                    if (cnt_reg == CNT_BIT_END) begin
                        cnt_reg <= '0;
                        // Leaving at mid-stop lets an immediately following start bit be seen.
                        state_reg <= IDLE;
                        if (rx_s == STOP_LEVEL) begin
                            data_reg  <= shift_reg;
                            valid_reg <= 1'b1;
                        end else begin
                            frame_err_reg <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.data      = data_reg;
    assign bus.valid     = valid_reg;
    assign bus.frame_err = frame_err_reg;
    assign bus.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a 16 clk/bit instance plus a default-rate instance for skew tests.
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    uart_rx_if fast_if ();
    uart_rx_if def_if ();

    uart_rx #(.BAUD(1), .F(16)) u_fast (
        .clk (clk),
        .rst (rst),
        .bus (fast_if)
    );

    uart_rx u_def (
        .clk (clk),
        .rst (rst),
        .bus (def_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorders for both instances, sampled on the falling edge.
    int   f_vcnt = 0, f_fecnt = 0, f_vrun = 0, f_vrun_max = 0, f_ferun = 0, f_ferun_max = 0, f_both = 0;
    int   f_vtime[$];
    logic [7:0] f_vdata[$];
    bit   f_busy_seen = 1'b0;
    int   d_vcnt = 0, d_fecnt = 0, d_vrun = 0, d_vrun_max = 0, d_both = 0;
    logic [7:0] d_last = 8'h00;

    always @(negedge clk) begin
        if (fast_if.valid === 1'b1) begin
            f_vcnt++;
            f_vtime.push_back(cyc);
            f_vdata.push_back(fast_if.data);
            f_vrun++;
            if (f_vrun > f_vrun_max) f_vrun_max = f_vrun;
        end else begin
            f_vrun = 0;
        end
        if (fast_if.frame_err === 1'b1) begin
            f_fecnt++;
            f_ferun++;
            if (f_ferun > f_ferun_max) f_ferun_max = f_ferun;
        end else begin
            f_ferun = 0;
        end
        if (fast_if.valid === 1'b1 && fast_if.frame_err === 1'b1) f_both++;
        if (fast_if.busy === 1'b1) f_busy_seen = 1'b1;
    end

    always @(negedge clk) begin
        if (def_if.valid === 1'b1) begin
            d_vcnt++;
            d_last = def_if.data;
            d_vrun++;
            if (d_vrun > d_vrun_max) d_vrun_max = d_vrun;
        end else begin
            d_vrun = 0;
        end
        if (def_if.frame_err === 1'b1) d_fecnt++;
        if (def_if.valid === 1'b1 && def_if.frame_err === 1'b1) d_both++;
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_rx(input bit def, input logic v);
        if (def) def_if.rx = v;
        else     fast_if.rx = v;
    endtask

    // Caller is always positioned on a falling edge; frames are emitted with no leading gap.
    task automatic send_frame(input bit def, input logic [7:0] b, input int clks, input logic stop);
        set_rx(def, 1'b0);
        hold(clks);
        for (int i = 0; i < 8; i++) begin
            set_rx(def, b[i]);
            hold(clks);
        end
        set_rx(def, stop);
        hold(clks);
        set_rx(def, 1'b1);
    endtask

    task automatic test_reset;
        fast_if.rx = 1'b1;
        def_if.rx  = 1'b1;
        rst = 1'b0;
        hold(3);
        checks++; if (fast_if.data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", fast_if.data); end
        checks++; if (fast_if.valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", fast_if.valid); end
        checks++; if (fast_if.frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b expected 0", fast_if.frame_err); end
        checks++; if (fast_if.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", fast_if.busy); end
        checks++; if (def_if.data !== 8'h00 || def_if.busy !== 1'b0) begin failures++; $display("FAIL reset_def: got data=%h busy=%b expected 00/0", def_if.data, def_if.busy); end
        rst = 1'b1;
        hold(5);
        checks++; if (fast_if.busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset_busy: got %b expected 0", fast_if.busy); end
        $display("reset: data=%h valid=%b frame_err=%b busy=%b", fast_if.data, fast_if.valid, fast_if.frame_err, fast_if.busy);
    endtask

    task automatic test_basic;
        int v0, fe0, t0, lat;
        v0 = f_vcnt; fe0 = f_fecnt; f_vrun_max = 0; f_both = 0;
        f_vtime.delete(); f_vdata.delete();
        t0 = cyc;
        send_frame(1'b0, 8'h55, 16, 1'b1);
        hold(40);
        lat = (f_vtime.size() > 0) ? f_vtime[0] - t0 : -1;
        checks++; if (f_vcnt - v0 !== 1) begin failures++; $display("FAIL basic_valid_count: got %0d expected 1", f_vcnt - v0); end
        checks++; if (fast_if.data !== 8'h55) begin failures++; $display("FAIL basic_data: got %h expected 55", fast_if.data); end
        checks++; if (f_fecnt - fe0 !== 0) begin failures++; $display("FAIL basic_frame_err: got %0d pulses expected 0", f_fecnt - fe0); end
        checks++; if (f_vrun_max !== 1) begin failures++; $display("FAIL basic_valid_width: got %0d expected 1", f_vrun_max); end
        checks++; if (lat < 153 || lat > 157) begin failures++; $display("FAIL basic_latency: got %0d expected 155 +/-2", lat); end
        $display("basic: byte=55 data=%h valid_pulses=%0d latency=%0d", fast_if.data, f_vcnt - v0, lat);
    endtask

    task automatic test_back_to_back;
        int gap;
        f_vtime.delete(); f_vdata.delete(); f_vrun_max = 0;
        send_frame(1'b0, 8'hA3, 16, 1'b1);
        send_frame(1'b0, 8'h0F, 16, 1'b1);
        hold(40);
        checks++; if (f_vtime.size() !== 2) begin failures++; $display("FAIL b2b_count: got %0d expected 2", f_vtime.size()); end
        if (f_vtime.size() == 2) begin
            gap = f_vtime[1] - f_vtime[0];
            checks++; if (gap < 158 || gap > 162) begin failures++; $display("FAIL b2b_gap: got %0d expected 160 +/-2", gap); end
            checks++; if (f_vdata[0] !== 8'hA3) begin failures++; $display("FAIL b2b_first: got %h expected a3", f_vdata[0]); end
            checks++; if (f_vdata[1] !== 8'h0F) begin failures++; $display("FAIL b2b_second: got %h expected 0f", f_vdata[1]); end
            $display("back_to_back: data %h then %h gap=%0d", f_vdata[0], f_vdata[1], gap);
        end
        checks++; if (f_vrun_max !== 1) begin failures++; $display("FAIL b2b_valid_width: got %0d expected 1", f_vrun_max); end
    endtask

    task automatic test_glitch;
        int v0, fe0;
        v0 = f_vcnt; fe0 = f_fecnt; f_busy_seen = 1'b0;
        set_rx(1'b0, 1'b0);
        hold(4);
        set_rx(1'b0, 1'b1);
        hold(30);
        checks++; if (f_busy_seen !== 1'b1) begin failures++; $display("FAIL glitch_busy_seen: got %b expected 1", f_busy_seen); end
        checks++; if (fast_if.busy !== 1'b0) begin failures++; $display("FAIL glitch_back_idle: got busy=%b expected 0", fast_if.busy); end
        checks++; if (f_vcnt - v0 !== 0 || f_fecnt - fe0 !== 0) begin failures++; $display("FAIL glitch_strobes: got valid=%0d frame_err=%0d expected 0/0", f_vcnt - v0, f_fecnt - fe0); end
        $display("glitch: busy_seen=%b valid_pulses=%0d frame_err_pulses=%0d", f_busy_seen, f_vcnt - v0, f_fecnt - fe0);
    endtask

    task automatic test_frame_err;
        int v0, fe0;
        v0 = f_vcnt; fe0 = f_fecnt; f_ferun_max = 0; f_both = 0;
        send_frame(1'b0, 8'hC8, 16, 1'b0);
        hold(40);
        checks++; if (f_fecnt - fe0 !== 1) begin failures++; $display("FAIL ferr_count: got %0d expected 1", f_fecnt - fe0); end
        checks++; if (f_vcnt - v0 !== 0) begin failures++; $display("FAIL ferr_no_valid: got %0d expected 0", f_vcnt - v0); end
        checks++; if (fast_if.data !== 8'h0F) begin failures++; $display("FAIL ferr_data_kept: got %h expected 0f", fast_if.data); end
        checks++; if (f_ferun_max !== 1 || f_both !== 0) begin failures++; $display("FAIL ferr_pulse_shape: got width=%0d overlap=%0d expected 1/0", f_ferun_max, f_both); end
        $display("frame_err: byte=c8 frame_err_pulses=%0d data=%h", f_fecnt - fe0, fast_if.data);
    endtask

    task automatic test_reset_mid;
        int v0, fe0;
        logic [7:0] b;
        b = 8'h5A;
        v0 = f_vcnt; fe0 = f_fecnt;
        set_rx(1'b0, 1'b0);
        hold(16);
        for (int i = 0; i < 4; i++) begin
            set_rx(1'b0, b[i]);
            hold(16);
        end
        checks++; if (fast_if.busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before: got %b expected 1", fast_if.busy); end
        rst = 1'b0;
        #1;
        checks++; if (fast_if.busy !== 1'b0 || fast_if.data !== 8'h00) begin failures++; $display("FAIL midrst_async: got busy=%b data=%h expected 0/00", fast_if.busy, fast_if.data); end
        set_rx(1'b0, 1'b1);
        hold(4);
        checks++; if (fast_if.valid !== 1'b0 || fast_if.frame_err !== 1'b0) begin failures++; $display("FAIL midrst_strobes: got valid=%b frame_err=%b expected 0/0", fast_if.valid, fast_if.frame_err); end
        rst = 1'b1;
        hold(20);
        checks++; if (f_vcnt - v0 !== 0 || f_fecnt - fe0 !== 0 || fast_if.busy !== 1'b0) begin failures++; $display("FAIL midrst_aborted: got valid=%0d frame_err=%0d busy=%b expected 0/0/0", f_vcnt - v0, f_fecnt - fe0, fast_if.busy); end
        send_frame(1'b0, 8'h7E, 16, 1'b1);
        hold(40);
        checks++; if (f_vcnt - v0 !== 1) begin failures++; $display("FAIL midrst_valid_count: got %0d expected 1", f_vcnt - v0); end
        checks++; if (fast_if.data !== 8'h7E) begin failures++; $display("FAIL midrst_data: got %h expected 7e", fast_if.data); end
        $display("reset_mid: after recovery data=%h valid_pulses=%0d", fast_if.data, f_vcnt - v0);
    endtask

    task automatic test_skew;
        int v0, fe0;
        int bit_clks[2];
        bit_clks[0] = 443;
        bit_clks[1] = 425;
        d_vrun_max = 0; d_both = 0;
        for (int k = 0; k < 2; k++) begin
            v0 = d_vcnt; fe0 = d_fecnt;
            send_frame(1'b1, 8'h31, bit_clks[k], 1'b1);
            hold(500);
            checks++; if (d_vcnt - v0 !== 1) begin failures++; $display("FAIL skew_valid_count_%0d: got %0d expected 1", bit_clks[k], d_vcnt - v0); end
            checks++; if (d_last !== 8'h31) begin failures++; $display("FAIL skew_data_%0d: got %h expected 31", bit_clks[k], d_last); end
            checks++; if (d_fecnt - fe0 !== 0) begin failures++; $display("FAIL skew_frame_err_%0d: got %0d expected 0", bit_clks[k], d_fecnt - fe0); end
            $display("skew: clks_per_bit=%0d data=%h valid_pulses=%0d", bit_clks[k], d_last, d_vcnt - v0);
        end
        checks++; if (d_vrun_max !== 1 || d_both !== 0) begin failures++; $display("FAIL skew_pulse_shape: got width=%0d overlap=%0d expected 1/0", d_vrun_max, d_both); end
    endtask

    initial begin
        fast_if.rx = 1'b1;
        def_if.rx  = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_skew();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that is the receive-side counterpart of the board's 8N1 transmitter, at the same BAUD/F parameters. It synchronises the asynchronous serial line and detects the start bit. It samples each bit at mid-period and presents the assembled byte with a one-cycle valid strobe to the fabric logic. It sits between the RX pin and consumer logic such as an echo path or command parser.

Parameters:
BAUD, 115200, line bit rate in bits/s
F, 50000000, clk frequency in Hz
CLKS_PER_BIT (localparam), F/BAUD (integer division), clk cycles per bit (434 at defaults); must be >= 8
HALF_BIT (localparam), CLKS_PER_BIT/2, start-bit mid-sample offset (217 at defaults)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
rx  input  1  serial line, idle high, asynchronous to clk
data  output  8  last correctly received byte, LSB = first data bit
valid  output  1  one-cycle pulse; data is new and stable from this cycle
frame_err  output  1  one-cycle pulse; stop bit sampled low
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, async): data=8'h00, valid=0, frame_err=0, busy=0, state=IDLE, counters=0, both synchroniser flops=1 (line idle).
- rx passes through a 2-flop synchroniser to rx_s. All decisions use rx_s only; this adds 2 clk of latency.
- Bit counter cnt is 16 bits wide, and bit index idx is 3 bits wide.
- IDLE: when rx_s=0 (falling edge, since the line was high), go to START with cnt=0.
- START: cnt increments each cycle. When cnt==HALF_BIT-1, sample rx_s:
  - 0: go to DATA with cnt=0, idx=0.
  - 1: treat as a glitch and return to IDLE. No strobe.
- DATA: cnt increments each cycle. When cnt==CLKS_PER_BIT-1:
  - shift rx_s into shift[idx] (LSB first), then cnt=0.
  - if idx==7, go to STOP; otherwise idx++.
- STOP: when cnt==CLKS_PER_BIT-1, sample rx_s:
  - 1: data<=shift, valid=1 for exactly that clock edge's next cycle.
  - 0: frame_err=1 for one cycle, and data keeps its previous value.
  - Either way, go to IDLE.
- Return to IDLE at mid-stop, so a start bit arriving immediately after the stop bit is caught.
- After a frame error with the line held low (break condition), IDLE sees rx_s=0 and re-enters START. Each break period then yields frame_err pulses, and never valid.
- valid and frame_err are never both high, and neither is high for more than one cycle.
- Latency: valid rises ~2 + HALF_BIT + 9*CLKS_PER_BIT clk after the rx falling edge (2 + 217 + 3906 = 4125 at defaults, ±1).
- rx changes mid-frame are ignored except at sample points. There is no majority vote.
- Reset asserted mid-frame aborts immediately with no strobe. After release, reception needs a fresh falling edge.
- The receiver has no backpressure. A new byte overwrites data; the consumer must capture it on valid.

Decomposition:
- Shared package (uart_pkg): state encoding IDLE/START/DATA/STOP (2 bits), frame constants DATA_BITS=8, STOP_LEVEL=1'b1, START_LEVEL=1'b0. uart_tx shares these.
- One sub-module: sync_2ff (1-bit, async active-low reset to parameterised value INIT=1). It is reusable for other asynchronous inputs.

Test Plan:
- F=16, BAUD=1 (CLKS_PER_BIT=16). Drive frame 0x55, 8N1, 16 clk/bit → valid one cycle, data=8'h55, frame_err never high.
- Back-to-back frames 0xA3 then 0x0F with no idle gap between stop and next start → two valid pulses 160±2 clk apart, data 8'hA3 then 8'h0F.
- rx low for 4 clk, then high (glitch < HALF_BIT) → busy pulses, returns to IDLE; no valid, no frame_err.
- Frame 0xC8 with stop bit driven low → frame_err pulse, valid stays 0, data keeps prior value 8'h0F.
- rst driven low at bit 4 of a frame, released, then clean frame 0x7E → outputs at reset values during rst; next frame gives data=8'h7E with a single valid.
- Defaults (434 clk/bit), frame 0x31 sent with a ±2% bit-time skew → data=8'h31 received correctly both slow and fast.
